// File: rtl/led_frame_sched_if.sv
// rtl/led_frame_sched_if.sv - pixel FIFO write port and serializer handshake for led_frame_sched
interface led_frame_sched_if #(
    parameter int CW = 4
);
    logic            we;
    logic [3*CW-1:0] fifo_data_in;
    logic            fifo_full;
    logic            send_start;
    logic            send_done;

    modport master (
        output we,
        output fifo_data_in,
        output send_start,
        input  fifo_full,
        input  send_done
    );

    modport slave (
        input  we,
        input  fifo_data_in,
        input  send_start,
        output fifo_full,
        output send_done
    );
endinterface

// File: rtl/led_frame_sched.sv
// rtl/led_frame_sched.sv - clk_slow frame scheduler: snapshot means, load pixel FIFO, kick serializer
// Optional gamma-2.2 component LUT at snapshot time when LED_GAMMA_EN is defined.
module led_frame_sched #(
    parameter int NPIX = 16,
    parameter int CW   = 4
) (
    input  logic                 clk_slow,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [NPIX*CW-1:0]   mean_r,
    input  logic [NPIX*CW-1:0]   mean_g,
    input  logic [NPIX*CW-1:0]   mean_b,
    led_frame_sched_if.master    fif,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic                 ovr
);
    localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_LOAD,
        S_KICK,
        S_WAIT_TX
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   idx_q;
    logic [3*CW-1:0] snap_q [NPIX];
    logic            wr;
    logic            kick;

`ifdef LED_GAMMA_EN
    // Nibble i holds the gamma-2.2 output for input i.
    localparam logic [63:0] GAMMA_LUT = 64'hFDB9_8654_3211_0000;

    function automatic logic [CW-1:0] gamma_map(input logic [CW-1:0] v);
        logic [3:0] sel;
        sel = 4'(v);
        return CW'(GAMMA_LUT[{sel, 2'b00} +: 4]);
    endfunction
`else
    function automatic logic [CW-1:0] gamma_map(input logic [CW-1:0] v);
        return v;
    endfunction
`endif

    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr      = 1'b0;
        kick    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && en) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                wr = !fif.fifo_full;
                if (wr && (idx_q == IW'(NPIX - 1))) begin
                    state_d = S_KICK;
                end
            end
            S_KICK: begin
                kick    = 1'b1;
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (fif.send_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            frame_cnt <= '0;
            ovr       <= 1'b0;
            for (int i = 0; i < NPIX; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            if (state_q == S_LATCH) begin
                idx_q <= '0;
                for (int i = 0; i < NPIX; i++) begin
                    snap_q[i] <= {gamma_map(mean_r[CW*i +: CW]),
                                  gamma_map(mean_g[CW*i +: CW]),
                                  gamma_map(mean_b[CW*i +: CW])};
                end
            end else if (wr) begin
                idx_q <= idx_q + 1'b1;
            end
            if (kick) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            // Any request while a frame is in flight is dropped but remembered.
            if (start && (state_q != S_IDLE)) begin
                ovr <= 1'b1;
            end
        end
    end

    assign fif.we           = wr;
    assign fif.fifo_data_in = snap_q[idx_q];
    assign fif.send_start   = kick;
    assign busy             = (state_q != S_IDLE);
endmodule

// File: tb/tb_led_frame_sched.sv
// tb/tb_led_frame_sched.sv - self-checking bench for led_frame_sched (vector table + write scoreboard)
module tb_led_frame_sched;
    localparam int NPIX = 16;
    localparam int CW   = 4;

    logic             clk_slow = 1'b0;
    logic             rst;
    logic             en;
    logic             start;
    logic [NPIX*CW-1:0] mean_r, mean_g, mean_b;
    logic             busy;
    logic [15:0]      frame_cnt;
    logic             ovr;

    led_frame_sched_if #(.CW(CW)) fif();

    led_frame_sched #(.NPIX(NPIX), .CW(CW)) dut (
        .clk_slow  (clk_slow),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .mean_r    (mean_r),
        .mean_g    (mean_g),
        .mean_b    (mean_b),
        .fif       (fif),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .ovr       (ovr)
    );

    always #10 clk_slow = ~clk_slow;

    int total  = 0;
    int bad    = 0;
    int cycle  = 0;
    int writes = 0;
    int kicks  = 0;
    int last_kick = 0;
    logic [11:0] exp_q [$];

    always @(posedge clk_slow) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every FIFO write must match the head of the expected-word queue.
    always @(negedge clk_slow) begin
        if (fif.we === 1'b1) begin
            writes++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %03h expected no write", fif.fifo_data_in);
            end else begin
                check("write_word", 32'(fif.fifo_data_in), 32'(exp_q.pop_front()));
            end
        end
        if (fif.send_start === 1'b1) begin
            kicks++;
            last_kick = cycle;
        end
    end

    function automatic logic [3:0] gm(input logic [3:0] v);
`ifdef LED_GAMMA_EN
        case (v)
            4'd0, 4'd1, 4'd2, 4'd3: return 4'd0;
            4'd4, 4'd5:             return 4'd1;
            4'd6:                   return 4'd2;
            4'd7:                   return 4'd3;
            4'd8:                   return 4'd4;
            4'd9:                   return 4'd5;
            4'd10:                  return 4'd6;
            4'd11:                  return 4'd8;
            4'd12:                  return 4'd9;
            4'd13:                  return 4'd11;
            4'd14:                  return 4'd13;
            default:                return 4'd15;
        endcase
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_slow);
        #5;
    endtask

    task automatic launch(input logic [63:0] r, input logic [63:0] g, input logic [63:0] b, output int k);
        mean_r = r;
        mean_g = g;
        mean_b = b;
        for (int i = 0; i < NPIX; i++) begin
            exp_q.push_back({gm(r[4*i +: 4]), gm(g[4*i +: 4]), gm(b[4*i +: 4])});
        end
        start = 1'b1;
        tick();
        k = cycle;
        start = 1'b0;
        tick();
        // Snapshot was taken at the previous edge; later input changes must not leak out.
        mean_r = {$urandom, $urandom};
        mean_g = {$urandom, $urandom};
        mean_b = {$urandom, $urandom};
    endtask

    task automatic wait_kick(input int kc0, input int w0, input int stall_after, input int stall_len,
                             input string name);
        int  budget;
        bit  stalled;
        budget  = 0;
        stalled = 1'b0;
        while (kicks == kc0 && budget < 300) begin
            if (!stalled && stall_len > 0 && (writes - w0) == stall_after) begin
                fif.fifo_full = 1'b1;
                repeat (stall_len) tick();
                fif.fifo_full = 1'b0;
                stalled = 1'b1;
            end else begin
                tick();
                budget++;
            end
        end
        if (budget >= 300) begin
            total++;
            bad++;
            $display("FAIL %s_kick_timeout: got no send_start expected one within 300 cycles", name);
        end
    endtask

    task automatic run_frame(input logic [63:0] r, input logic [63:0] g, input logic [63:0] b,
                             input int stall_after, input int stall_len, input int exp_delay,
                             input logic [15:0] exp_cnt, input string name);
        int k, w0, kc0;
        w0  = writes;
        kc0 = kicks;
        launch(r, g, b, k);
        wait_kick(kc0, w0, stall_after, stall_len, name);
        check({name, "_kick_delay"}, 32'(last_kick - k), 32'(exp_delay));
        check({name, "_writes"}, 32'(writes - w0), 32'(NPIX));
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
        check({name, "_busy_wait"}, 32'(busy), 32'd1);
        fif.send_done = 1'b1;
        tick();
        fif.send_done = 1'b0;
        check({name, "_busy_idle"}, 32'(busy), 32'd0);
        check({name, "_kicks"}, 32'(kicks - kc0), 32'd1);
    endtask

    typedef struct {
        logic [63:0] r;
        logic [63:0] g;
        logic [63:0] b;
        int          stall_after;
        int          stall_len;
        int          delay;
    } vec_t;

    logic [63:0] basic_r;
    vec_t        vecs [5];

    initial begin
        int k, w0, kc0;

        for (int i = 0; i < NPIX; i++) begin
            basic_r[4*i +: 4] = 4'((i % 8) + 1);
        end
        vecs[0] = '{basic_r, 64'h0, 64'h0, 0, 0, 17};
        vecs[1] = '{basic_r, 64'h0, 64'h0, 4, 5, 22};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h5A5A_A5A5_3C3C_C3C3, 8, 1, 18};
        vecs[3] = '{{16{4'h8}}, {16{4'h8}}, {16{4'h8}}, 0, 0, 17};
        vecs[4] = '{{16{4'hF}}, {16{4'h9}}, {16{4'h1}}, 15, 3, 20};

        rst = 1'b1;
        en = 1'b0;
        start = 1'b0;
        mean_r = '0;
        mean_g = '0;
        mean_b = '0;
        fif.fifo_full = 1'b0;
        fif.send_done = 1'b0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_we", 32'(fif.we), 32'd0);
        check("reset_data", 32'(fif.fifo_data_in), 32'd0);
        check("reset_send_start", 32'(fif.send_start), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        check("reset_ovr", 32'(ovr), 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].stall_after, vecs[i].stall_len,
                      vecs[i].delay, 16'(i + 1), $sformatf("vec%0d", i));
        end
        check("no_ovr_after_table", 32'(ovr), 32'd0);

        // Request with en low in IDLE: nothing happens and ovr is untouched.
        en = 1'b0;
        w0 = writes;
        kc0 = kicks;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("gated_busy", 32'(busy), 32'd0);
        repeat (20) tick();
        check("gated_writes", 32'(writes - w0), 32'd0);
        check("gated_kicks", 32'(kicks - kc0), 32'd0);
        check("gated_ovr", 32'(ovr), 32'd0);

        // Overrun during LOAD, en dropped mid-frame, then start coincident with send_done.
        en = 1'b1;
        w0 = writes;
        kc0 = kicks;
        launch(basic_r, 64'h0, 64'h0, k);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        en = 1'b0;
        check("ovr_set_in_load", 32'(ovr), 32'd1);
        wait_kick(kc0, w0, 0, 0, "ovr_frame");
        check("ovr_frame_delay", 32'(last_kick - k), 32'd17);
        check("ovr_frame_writes", 32'(writes - w0), 32'(NPIX));
        check("ovr_frame_cnt", 32'(frame_cnt), 32'd6);
        en = 1'b1;
        tick();
        fif.send_done = 1'b1;
        start = 1'b1;
        tick();
        fif.send_done = 1'b0;
        start = 1'b0;
        check("done_start_busy", 32'(busy), 32'd0);
        repeat (20) tick();
        check("done_start_writes", 32'(writes - w0), 32'(NPIX));
        check("done_start_kicks", 32'(kicks - kc0), 32'd1);
        check("done_start_cnt", 32'(frame_cnt), 32'd6);
        check("ovr_sticky", 32'(ovr), 32'd1);

        // Asynchronous reset after 7 writes aborts the frame with no kick.
        w0 = writes;
        kc0 = kicks;
        launch(basic_r, 64'h0, 64'h0, k);
        for (int n = 0; n < 50 && (writes - w0) < 7; n++) tick();
        check("pre_reset_writes", 32'(writes - w0), 32'd7);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_we", 32'(fif.we), 32'd0);
        check("midrst_data", 32'(fif.fifo_data_in), 32'd0);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("midrst_ovr", 32'(ovr), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        repeat (25) tick();
        check("midrst_no_kick", 32'(kicks - kc0), 32'd0);
        check("midrst_writes", 32'(writes - w0), 32'd7);
        run_frame(basic_r, 64'h0, 64'h0, 0, 0, 17, 16'd1, "post_reset");

        // Counter wrap: preload 65535 and run one more frame.
        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        tick();
        check("wrap_preload", 32'(frame_cnt), 32'h0000_FFFF);
        run_frame({16{4'h8}}, {16{4'h8}}, {16{4'h8}}, 0, 0, 17, 16'd0, "wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_frame_sched.md
# led_frame_sched

Frame scheduler on the `clk_slow` side of the LED controller. On a `start` pulse it snapshots the 16-pixel RGB mean arrays, packs each pixel into a 12-bit word and writes the words into the cross-domain pixel FIFO under `fifo_full` backpressure. It then issues a one-cycle `send_start` to the `clk_fast` serializer and holds off further frames until the serializer reports `send_done`.

## Interface
- `NPIX`, 16: pixels per frame.
- `CW`, 4: bits per colour component.
- `clk_slow` in 1: sole clock, 50 MHz; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: level enable. When low, no new frame is accepted.
- `start` in 1: single-cycle frame request.
- `mean_r`, `mean_g`, `mean_b` in NPIX*CW each: packed means. Pixel i occupies bits [CW*i+CW-1:CW*i].
- `fifo_full` in 1: pixel FIFO full flag, already in the `clk_slow` domain.
- `send_done` in 1: single-cycle pulse, already synchronized from `clk_fast`; means the serializer has drained the frame.
- `we` out 1: FIFO write strobe.
- `fifo_data_in` out 3*CW: pixel word {R,G,B}, with R in [11:8] and B in [3:0].
- `send_start` out 1: single-cycle kick to the serializer.
- `busy` out 1: high whenever state ≠ IDLE.
- `frame_cnt` out 16: count of frames kicked.
- `ovr` out 1: sticky overrun flag.

## Operation
- States: IDLE, LATCH, LOAD, KICK, WAIT_TX.
- IDLE:
  - `start`=1 and `en`=1 → LATCH.
  - `start` with `en`=0 → ignored. Does not set `ovr`.
- LATCH: captures `mean_r/g/b` into snapshot registers and clears `idx` to 0 → LOAD.
- LOAD:
  - `we` = !`fifo_full` (combinational). `fifo_data_in` = snapshot word[`idx`].
  - When `we`=1, `idx` increments at the edge.
  - When `fifo_full`=1, `we`=0 and `idx` holds. Backpressure can last indefinitely; there is no timeout.
  - Write with `idx`=NPIX-1 → KICK.
- KICK: `send_start`=1 for exactly one cycle. `frame_cnt` increments, wrapping 65535→0 → WAIT_TX.
- WAIT_TX: `send_done`=1 → IDLE. `send_done` in any other state is ignored.
- Overrun: `start`=1 in any state other than IDLE sets `ovr`. `ovr` clears only on `rst`. This includes `start` arriving in the same cycle as `send_done` in WAIT_TX; that request is dropped.
- Deasserting `en` mid-frame does not abort. The current frame completes through WAIT_TX. No new frame is accepted afterwards.
- Input means may change freely after LATCH. Only the snapshot is sent.
- Pixels are written in order 0..NPIX-1. Exactly NPIX writes occur per frame.

## Timing
- Reset values: state IDLE, `idx`=0, snapshot=0, `we`=0, `fifo_data_in`=0, `send_start`=0, `busy`=0, `frame_cnt`=0, `ovr`=0.
- Reset takes effect asynchronously, mid-frame included. No `send_start` is issued for the aborted frame. Any partial frame left in the FIFO is flushed by the FIFO's own reset.
- Reference edge: `start` sampled at edge k.
  - LATCH during cycle k→k+1.
  - With no backpressure, `we`=1 for 16 consecutive cycles. The FIFO samples the first word at edge k+2 and the last at edge k+17.
  - `send_start` is high between edges k+17 and k+18.
  - `busy` rises after edge k.
- Each cycle of `fifo_full`=1 during LOAD adds exactly one cycle to the k+17 figure.
- Earliest next accepted `start` is the edge after `send_done` is sampled.

## Configuration
- `LED_GAMMA_EN` defined: each 4-bit component passes through a gamma-2.2 LUT at LATCH. Input 0..15 maps to 0,0,0,0,1,1,2,3,4,5,6,8,9,11,13,15. Latency is unchanged.
- `LED_GAMMA_EN` undefined: components are passed unmodified.

## Test plan
- Basic frame:
  - Stimulus: `mean_r` pixel i = (i%8)+1, `mean_g`=`mean_b`=0, `en`=1, `fifo_full`=0, one `start`.
  - Required: 16 writes 0x100,0x200,…,0x800,0x100,…,0x800; `send_start` at edge k+17; `frame_cnt`=1.
- Backpressure:
  - Stimulus: hold `fifo_full`=1 for 5 cycles after the 4th write.
  - Required: `we`=0 during the stall, no word skipped or duplicated, `send_start` at edge k+22.
- Overrun and gating:
  - Stimulus: `start` during LOAD; `start` during WAIT_TX coincident with `send_done`; `start` with `en`=0 in IDLE.
  - Required: `ovr`=1 after the first case, no extra frame from either busy-state request, and the `en`=0 request produces nothing with `ovr` unaffected.
- Reset mid-LOAD:
  - Stimulus: assert `rst` after 7 writes.
  - Required: all outputs return to reset values immediately and no `send_start` occurs. A later `start` produces a full 16-word frame.
- Wrap and gamma:
  - Stimulus: preload `frame_cnt` via 65536 frames (or force) and run one more frame; separately, with `LED_GAMMA_EN`, send all components = 8.
  - Required: `frame_cnt` goes 65535→0; the gamma frame writes 0x444 for every pixel.
